// File: rtl/mmio_bus_if.sv
// CPU-side MMIO request/response channel.
// One request in flight; completion is a one-cycle ready pulse.
interface mmio_bus_if;
  logic        cpu_valid_i;
  logic        cpu_ready_o;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [3:0]  cpu_wstrb_i;
  logic [31:0] cpu_rdata_o;

  modport master (
    output cpu_valid_i,
    output cpu_addr_i,
    output cpu_wdata_i,
    output cpu_wstrb_i,
    input  cpu_ready_o,
    input  cpu_rdata_o
  );

  modport slave (
    input  cpu_valid_i,
    input  cpu_addr_i,
    input  cpu_wdata_i,
    input  cpu_wstrb_i,
    output cpu_ready_o,
    output cpu_rdata_o
  );
endinterface

// File: rtl/mmio_bus.sv
// MMIO decoder: routes one CPU request to a peripheral slot,
// with a wait timeout, error response and sticky error flag.
module mmio_bus #(
  parameter int          NSLOTS   = 8,
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  mmio_bus_if.slave              cpu,
  output logic [NSLOTS-1:0]      per_select_o,
  output logic [31:0]            per_addr_o,
  output logic [31:0]            per_wdata_o,
  output logic [3:0]             per_wstrb_o,
  input  logic [NSLOTS-1:0]      per_ready_i,
  input  logic [NSLOTS*32-1:0]   per_rdata_i,
  output logic                   err_o,
  input  logic                   err_clr_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0] NS = 5'(NSLOTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    slot_q;
  logic [3:0]    slot_in;
  logic [3:0]    wstrb_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          hit;
  logic [15:0]   rdy_all;
  logic [511:0]  rd_all;
  logic          slv_rdy;
  logic [31:0]   slv_data;
  logic          in_wait;

  assign slot_in = cpu.cpu_addr_i[11:8];
  assign hit = (cpu.cpu_addr_i[31:12] == BASE[31:12])
            && ({1'b0, slot_in} < NS);

  // Pad slot vectors to 16 so the 4-bit slot index is always legal.
  assign rdy_all  = 16'(per_ready_i);
  assign rd_all   = 512'(per_rdata_i);
  assign slv_rdy  = rdy_all[slot_q];
  assign slv_data = rd_all[{slot_q, 5'b0} +: 32];
  assign in_wait  = (state_q == S_WAIT);

  // Next-state logic; ready in the last wait cycle beats timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu.cpu_valid_i) begin
          state_d = hit ? S_WAIT : S_ERR;
        end
      end
      S_WAIT: begin
        if (slv_rdy) begin
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latches, saturating wait counter, error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cpu.cpu_valid_i) begin
        addr_q  <= cpu.cpu_addr_i;
        wdata_q <= cpu.cpu_wdata_i;
        wstrb_q <= cpu.cpu_wstrb_i;
        slot_q  <= slot_in;
        cnt_q   <= '0;
      end else if (in_wait && !slv_rdy && cnt_q != '1) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (in_wait && slv_rdy) begin
        rdata_q <= slv_data;
      end
      if (state_d == S_ERR) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign cpu.cpu_ready_o = (state_q == S_RESP)
                        || (state_q == S_ERR);
  assign cpu.cpu_rdata_o = (state_q == S_RESP) ? rdata_q
                         : (state_q == S_ERR)  ? ERR_DATA
                         : 32'h0;

  assign per_select_o = in_wait ? NSLOTS'(16'd1 << slot_q)
                                : '0;
  assign per_wstrb_o  = in_wait ? wstrb_q : 4'b0;
  assign per_addr_o   = addr_q;
  assign per_wdata_o  = wdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mmio_bus.sv
// Randomized bench for mmio_bus against a transaction-level
// latency/response model (NSLOTS=8, TIMEOUT=4).
module tb_mmio_bus;
  localparam int NS = 8;
  localparam int TO = 4;
  localparam logic [31:0] ED = 32'hDEAD_BEEF;

  logic            clk_i;
  logic            rst_ni;
  logic [NS-1:0]   per_select_o;
  logic [31:0]     per_addr_o;
  logic [31:0]     per_wdata_o;
  logic [3:0]      per_wstrb_o;
  logic [NS-1:0]   per_ready_i;
  logic [NS*32-1:0] per_rdata_i;
  logic            err_o;
  logic            err_clr_i;

  int checks;
  int failures;
  logic err_m;

  mmio_bus_if bus();

  mmio_bus #(
    .NSLOTS(NS),
    .BASE(32'h8000_0000),
    .TIMEOUT(TO),
    .ERR_DATA(ED)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .cpu(bus.slave),
    .per_select_o(per_select_o),
    .per_addr_o(per_addr_o),
    .per_wdata_o(per_wdata_o),
    .per_wstrb_o(per_wstrb_o),
    .per_ready_i(per_ready_i),
    .per_rdata_i(per_rdata_i),
    .err_o(err_o),
    .err_clr_i(err_clr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // lat: WAIT cycles before the slave answers (0 = zero-wait),
  // negative = slave never answers.  sd: target slave data.
  task automatic txn(input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [3:0]  ws,
                     input int          lat,
                     input logic [31:0] sd,
                     input logic        clr0);
    bit          hit;
    int          slot;
    int          n_sel;
    int          r_cyc;
    logic [31:0] r_dat;
    bit          is_err;
    logic [NS-1:0] onehot;
    logic [NS-1:0] rv;
    logic [NS-1:0] es;
    slot = int'(a[11:8]);
    hit = (a[31:12] == 20'h80000) && (slot < NS);
    onehot = '0;
    if (hit) onehot[slot] = 1'b1;
    if (!hit) begin
      n_sel = 0; r_cyc = 1; r_dat = ED; is_err = 1;
    end else if (lat >= 0 && lat < TO) begin
      n_sel = lat + 1; r_cyc = lat + 2; r_dat = sd; is_err = 0;
    end else begin
      n_sel = TO; r_cyc = TO + 1; r_dat = ED; is_err = 1;
    end
    for (int k = 0; k < NS; k++)
      per_rdata_i[k*32 +: 32] = $urandom;
    if (hit) per_rdata_i[slot*32 +: 32] = sd;
    bus.cpu_valid_i = 1'b1;
    bus.cpu_addr_i  = a;
    bus.cpu_wdata_i = wd;
    bus.cpu_wstrb_i = ws;
    err_clr_i = clr0;
    per_ready_i = '0;
    for (int cyc = 1; cyc <= r_cyc + 1; cyc++) begin
      @(posedge clk_i);
      #1;
      if (cyc == 1) begin
        bus.cpu_valid_i = 1'b0;
        bus.cpu_addr_i  = $urandom;
        bus.cpu_wdata_i = $urandom;
        bus.cpu_wstrb_i = 4'($urandom);
        err_clr_i = 1'b0;
      end
      es = (cyc <= n_sel) ? onehot : '0;
      check("sel", 32'(per_select_o), 32'(es));
      check("wstrb", 32'(per_wstrb_o),
            (es != 0) ? 32'(ws) : 32'h0);
      if (es != 0) begin
        check("paddr", per_addr_o, a);
        check("pwdata", per_wdata_o, wd);
      end
      check("ready", 32'(bus.cpu_ready_o),
            (cyc == r_cyc) ? 32'h1 : 32'h0);
      check("rdata", bus.cpu_rdata_o,
            (cyc == r_cyc) ? r_dat : 32'h0);
      rv = NS'($urandom) & ~onehot;
      if (hit && lat >= 0 && cyc == lat + 1)
        rv[slot] = 1'b1;
      per_ready_i = rv;
    end
    per_ready_i = '0;
    if (clr0) err_m = 1'b0;
    if (is_err) err_m = 1'b1;
    check("err", 32'(err_o), 32'(err_m));
  endtask

  task automatic clr_err();
    err_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    err_clr_i = 1'b0;
    err_m = 1'b0;
    check("err_clr", 32'(err_o), 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    err_m = 1'b0;
    rst_ni = 1'b0;
    err_clr_i = 1'b0;
    bus.cpu_valid_i = 1'b0;
    bus.cpu_addr_i = 32'h0;
    bus.cpu_wdata_i = 32'h0;
    bus.cpu_wstrb_i = 4'h0;
    per_ready_i = '0;
    per_rdata_i = '0;
    #12;
    check("rst_sel", 32'(per_select_o), 32'h0);
    check("rst_rdy", 32'(bus.cpu_ready_o), 32'h0);
    check("rst_rdata", bus.cpu_rdata_o, 32'h0);
    check("rst_paddr", per_addr_o, 32'h0);
    check("rst_pwdata", per_wdata_o, 32'h0);
    check("rst_wstrb", 32'(per_wstrb_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    txn(32'h8000_0104, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
    txn(32'h8000_0000, 32'h3, 4'hF, 0, 32'h0, 1'b0);
    txn(32'h8000_0300, 32'h0, 4'h0, -1, 32'h5555_0000, 1'b0);
    clr_err();
    txn(32'h8000_0200, 32'h0, 4'h0, TO - 1, 32'hCAFE_F00D, 1'b0);
    txn(32'h9000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    clr_err();
    txn(32'h8000_0900, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    txn(32'h8000_0F10, 32'h0, 4'h1, 0, 32'h0, 1'b1);
    clr_err();

    // Reset during WAIT aborts with no response.
    bus.cpu_valid_i = 1'b1;
    bus.cpu_addr_i = 32'h8000_0300;
    bus.cpu_wstrb_i = 4'h5;
    bus.cpu_wdata_i = 32'hAAAA_5555;
    @(posedge clk_i);
    #1;
    bus.cpu_valid_i = 1'b0;
    check("abort_sel_pre", 32'(per_select_o), 32'h8);
    rst_ni = 1'b0;
    #1;
    check("abort_sel", 32'(per_select_o), 32'h0);
    check("abort_wstrb", 32'(per_wstrb_o), 32'h0);
    check("abort_rdy", 32'(bus.cpu_ready_o), 32'h0);
    check("abort_paddr", per_addr_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    err_m = 1'b0;
    @(posedge clk_i);
    #1;
    check("abort_rdy_post", 32'(bus.cpu_ready_o), 32'h0);
    txn(32'h8000_0504, 32'h77, 4'h3, 1, 32'h0BAD_F00D, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int kind;
      kind = int'($urandom_range(0, 5));
      a = $urandom;
      if (kind <= 3)
        a = {20'h80000, 1'b0, 3'($urandom), a[7:0]};
      else if (kind == 4)
        a = {20'h80000, 1'b1, 3'($urandom), a[7:0]};
      txn(a, $urandom,
          ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
          int'($urandom_range(0, 6)) - 1,
          $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) clr_err();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end
endmodule
